// File: rtl/ram_rom_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_rom_param_if
//  Purpose  : Request/response bundle between a requester and ram_rom_param.
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_rom_param_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 2
);
   logic              reinit;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      output reinit, req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  reinit, req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/ram_rom_param.sv
`default_nettype none
// ============================================================================
//  Module   : ram_rom_param
//  Purpose  : Self-initialising synchronous memory, low region write-protected.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_rom_param #(
   parameter int DATA_W    = 4,
   parameter int ADDR_W    = 2,
   parameter int ROM_LIMIT = 2,
   parameter int INIT_MODE = 2
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   ram_rom_param_if.slave  bus
);

   localparam int              c_depth     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] c_last    = ADDR_W'(c_depth - 1);
   localparam logic [ADDR_W:0]   c_rom_lim = (ADDR_W+1)'(ROM_LIMIT);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   logic [DATA_W-1:0] r_mem [c_depth];

   logic              w_accept;
   logic              w_prot;
   logic [DATA_W-1:0] w_init;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;

   // Init content for the word currently addressed by the init counter
   if (INIT_MODE == 0) begin : g_init_zero
      assign w_init = '0;
   end else if (INIT_MODE == 1) begin : g_init_index
      assign w_init = DATA_W'(r_cnt);
   end else begin : g_init_legacy
      logic [1:0] w_sel;
      logic [3:0] w_tab;
      assign w_sel = 2'(r_cnt);
      always_comb begin
         w_tab = 4'h4;
         case (w_sel)
            2'd0:    w_tab = 4'h4;
            2'd1:    w_tab = 4'hC;
            2'd2:    w_tab = 4'h6;
            default: w_tab = 4'h7;
         endcase
      end
      assign w_init = DATA_W'(w_tab);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      bus.busy      = 1'b0;
      bus.req_ready = 1'b0;
      case (r_state)
         ST_INIT: begin
            bus.busy  = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_last) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            bus.req_ready = !bus.reinit;
            if (bus.reinit) begin
               w_state_nxt = ST_INIT;
               w_cnt_nxt   = '0;
            end
         end
      endcase
   end

   assign w_accept = bus.req_valid && bus.req_ready;
   assign w_prot   = {1'b0, bus.req_addr} < c_rom_lim;

   // Init writes ignore protection so the ROM region gets its content
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = bus.req_addr;
      w_mem_wdata = bus.req_wdata;
      if (r_state == ST_INIT) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = r_cnt;
         w_mem_wdata = w_init;
      end else if (w_accept && bus.req_we && !w_prot) begin
         w_mem_we    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   // Read-before-write: the response carries the word as it was at accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_accept;
         if (w_accept) begin
            r_rsp_rdata <= r_mem[bus.req_addr];
            r_rsp_err   <= bus.req_we && w_prot;
         end
      end
   end

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_rom_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_rom_param
//  Purpose  : Scoreboard bench for ram_rom_param with default parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rom_param;
   localparam int DATA_W = 4;
   localparam int ADDR_W = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ram_rom_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram_rom_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROM_LIMIT(2), .INIT_MODE(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [DATA_W:0]   sb_q [$];
   logic [DATA_W:0]   mon_exp;
   logic [DATA_W-1:0] model [4];

   task automatic model_init();
      model[0] = 4'h4; model[1] = 4'hC; model[2] = 4'h6; model[3] = 4'h7;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 data=%h, required no response", bus.rsp_rdata);
         end else begin
            mon_exp = sb_q.pop_front();
            if ({bus.rsp_err, bus.rsp_rdata} !== mon_exp) begin
               failures++;
               $display("FAIL rsp: got err=%0b data=%h, required err=%0b data=%h",
                        bus.rsp_err, bus.rsp_rdata, mon_exp[DATA_W], mon_exp[DATA_W-1:0]);
            end
         end
      end
   end

   task automatic req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL req_ready: got %b, required 1 (addr %0d)", bus.req_ready, addr);
      end
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      sb_q.push_back({we && (addr < 2), model[addr]});
      if (we && addr >= 2) model[addr] = wdata;
      @(posedge clk); #1;
   endtask

   task automatic idle_drain();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL rsp_missing: got %0d outstanding, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic busy_window(input string name);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_init_c%0d: got busy=%b ready=%b, required busy=1 ready=0",
                     name, i, bus.busy, bus.req_ready);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_idle: got busy=%b ready=%b, required busy=0 ready=1",
                  name, bus.busy, bus.req_ready);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 4'h0 || bus.rsp_err !== 1'b0 ||
          bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s: got valid=%b data=%h err=%b busy=%b ready=%b, required 0/0/0/1/0",
                  name, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.busy, bus.req_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.reinit = 1'b0; bus.req_valid = 1'b0; bus.req_we = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0;
      repeat (2) begin @(posedge clk); #1; end
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      busy_window("por");
      model_init();
   endtask

   task automatic test_init_read();
      for (int a = 0; a < 4; a++) req(1'b0, ADDR_W'(a), '0);
      idle_drain();
   endtask

   task automatic test_write_ram();
      req(1'b1, 2'd3, 4'h9);
      idle_drain();
      req(1'b0, 2'd3, '0);
      idle_drain();
   endtask

   task automatic test_write_rom();
      req(1'b1, 2'd1, 4'hF);
      idle_drain();
      req(1'b0, 2'd1, '0);
      req(1'b1, 2'd0, 4'h3);
      req(1'b0, 2'd0, '0);
      idle_drain();
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 4; a++) req(1'b0, ADDR_W'(a), '0);
      req(1'b1, 2'd2, 4'h5);
      req(1'b0, 2'd2, '0);
      idle_drain();
   endtask

   task automatic test_reinit();
      req(1'b0, 2'd3, '0);
      bus.reinit    = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 2'd3;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL reinit_ready: got %b, required 0", bus.req_ready);
      end
      @(posedge clk); #1;
      bus.reinit    = 1'b0;
      bus.req_valid = 1'b0;
      busy_window("reinit");
      model_init();
      req(1'b0, 2'd3, '0);
      idle_drain();
   endtask

   task automatic test_reset_mid_init();
      bus.reinit = 1'b1;
      @(posedge clk); #1;
      bus.reinit = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_init");
      @(posedge clk); #1;
      rst_n = 1'b1;
      busy_window("rst_mid");
      model_init();
      req(1'b0, 2'd1, '0);
      req(1'b0, 2'd3, '0);
      idle_drain();
   endtask

   initial begin
      test_reset();
      test_init_read();
      test_write_ram();
      test_write_rom();
      test_back_to_back();
      test_reinit();
      test_reset_mid_init();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
